fft_unload: RTL and testbench

// Result reader for the 512-pt in-place FFT. On completion of the butterfly passes, streams
// all N complex bins out of the final ping-pong RAM bank, in index order, over a valid/ready

---
 rtl/fft_unload.sv | 155 +++++++++++++++
 tb/tb_fft_unload.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_unload.sv
// rtl/fft_unload.sv - streams the final FFT bank out in bin order over a valid/ready port
module fft_unload #(
    parameter int BIT_WIDTH = 16,
    parameter int level     = 9,
    parameter bit BITREV    = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic                   fft_start,
    input  logic                   res_bank,
    input  logic [2*BIT_WIDTH-1:0] rd_data0,
    input  logic [2*BIT_WIDTH-1:0] rd_data1,
    output logic [level-1:0]       rd_add,
    output logic                   rd_en,
    output logic                   rd_bank,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [BIT_WIDTH-1:0]   out_re,
    output logic [BIT_WIDTH-1:0]   out_im,
    output logic [level-1:0]       out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic                   unload_done
);

    localparam int DW = 2 * BIT_WIDTH;
    localparam logic [level-1:0] K_LAST = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic             fft_done_d;
    logic             fft_start_d;
    logic [level-1:0] k_issue;
    logic [level-1:0] k_out;
    logic             inflight;
    logic [DW-1:0]    fifo_data [2];
    logic [level-1:0] fifo_idx  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;

    logic             start;
    logic             abort;
    logic             pop;
    logic             push;
    logic [2:0]       outstanding;
    logic [DW-1:0]    ret_data;
    logic [DW-1:0]    head_data;
    logic [level-1:0] head_idx;

    function automatic logic [level-1:0] bit_reverse(input logic [level-1:0] a);
        logic [level-1:0] r;
        for (int i = 0; i < level; i++) begin
            r[i] = a[level-1-i];
        end
        return r;
    endfunction

    assign start = fft_done & ~fft_done_d;
    assign abort = fft_start & ~fft_start_d;

    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // Beats held or on their way back, after this cycle's pop; keeps the 2-entry FIFO from overflowing.
    assign outstanding = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en       = (state == RUN) && (outstanding < 3'd2);
    assign rd_add      = rd_en ? (BITREV ? bit_reverse(k_issue) : k_issue) : '0;

    assign ret_data  = rd_bank ? rd_data1 : rd_data0;
    assign head_data = fifo_data[rd_ptr];
    assign head_idx  = fifo_idx[rd_ptr];

    assign out_re      = out_valid ? head_data[DW-1:BIT_WIDTH] : '0;
    assign out_im      = out_valid ? head_data[BIT_WIDTH-1:0] : '0;
    assign out_index   = out_valid ? head_idx : '0;
    assign out_last    = out_valid && (head_idx == K_LAST);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign unload_done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fft_done_d   <= 1'b0;
            fft_start_d  <= 1'b0;
            k_issue      <= '0;
            k_out        <= '0;
            inflight     <= 1'b0;
            rd_bank      <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_idx[0]  <= '0;
            fifo_idx[1]  <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
        end else begin
            fft_done_d  <= fft_done;
            fft_start_d <= fft_start;
            if (abort) begin
                state    <= IDLE;
                inflight <= 1'b0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                fifo_cnt <= 2'd0;
            end else begin
                inflight <= rd_en;
                if (push) begin
                    fifo_data[wr_ptr] <= ret_data;
                    fifo_idx[wr_ptr]  <= k_out;
                    wr_ptr            <= ~wr_ptr;
                    if (k_out != K_LAST) begin
                        k_out <= k_out + level'(1);
                    end
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= RUN;
                            rd_bank <= res_bank;
                            k_issue <= '0;
                            k_out   <= '0;
                        end
                    end
                    RUN: begin
                        if (rd_en) begin
                            if (k_issue == K_LAST) begin
                                state <= DRAIN;
                            end else begin
                                k_issue <= k_issue + level'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (pop && (head_idx == K_LAST)) begin
                            state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_unload.sv
// tb/tb_fft_unload.sv - randomized self-checking bench for fft_unload
module tb_fft_unload;

    localparam int LV = 9;
    localparam int N  = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        fft_done, fft_start, res_bank, out_ready;
    logic [31:0] rd_data0, rd_data1;
    logic [8:0]  rd_add, out_index;
    logic        rd_en, rd_bank, out_valid, out_last, busy, unload_done;
    logic [15:0] out_re, out_im;

    logic        b_fft_done, b_fft_start, b_res_bank, b_out_ready;
    logic [31:0] b_rd_data0, b_rd_data1;
    logic [8:0]  b_rd_add, b_out_index;
    logic        b_rd_en, b_rd_bank, b_out_valid, b_out_last, b_busy, b_unload_done;
    logic [15:0] b_out_re, b_out_im;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram0 [0:N-1];
    logic [31:0] ram1 [0:N-1];
    int issued   = 0;
    int accepted = 0;
    int add_q[$];
    int b_add_q[$];

    fft_unload #(.BIT_WIDTH(16), .level(LV), .BITREV(1'b0)) dut (
        .clk(clk), .reset(reset), .fft_done(fft_done), .fft_start(fft_start),
        .res_bank(res_bank), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .rd_add(rd_add), .rd_en(rd_en), .rd_bank(rd_bank), .out_ready(out_ready),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_index(out_index),
        .out_last(out_last), .busy(busy), .unload_done(unload_done)
    );

    fft_unload #(.BIT_WIDTH(16), .level(LV), .BITREV(1'b1)) dut_br (
        .clk(clk), .reset(reset), .fft_done(b_fft_done), .fft_start(b_fft_start),
        .res_bank(b_res_bank), .rd_data0(b_rd_data0), .rd_data1(b_rd_data1),
        .rd_add(b_rd_add), .rd_en(b_rd_en), .rd_bank(b_rd_bank), .out_ready(b_out_ready),
        .out_valid(b_out_valid), .out_re(b_out_re), .out_im(b_out_im), .out_index(b_out_index),
        .out_last(b_out_last), .busy(b_busy), .unload_done(b_unload_done)
    );

    always #5 clk = ~clk;

    // Two-bank synchronous RAM model shared by both instances, plus issue/accept bookkeeping.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= ram0[rd_add];
            rd_data1 <= ram1[rd_add];
            issued   <= issued + 1;
            add_q.push_back(int'(rd_add));
        end
        if (out_valid && out_ready) accepted <= accepted + 1;
        if (b_rd_en) begin
            b_rd_data0 <= ram0[b_rd_add];
            b_rd_data1 <= ram1[b_rd_add];
            b_add_q.push_back(int'(b_rd_add));
        end
    end

    function automatic int rev_index(input int k);
        int r = 0;
        int x = k;
        for (int i = 0; i < LV; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_word(input bit bank, input int k, input bit br);
        int a;
        a = br ? rev_index(k) : k;
        return bank ? ram1[a] : ram0[a];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            ram0[i] = $urandom;
            ram1[i] = $urandom;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fft_done = 0; fft_start = 0; res_bank = 0; out_ready = 0;
        b_fft_done = 0; b_fft_start = 0; b_res_bank = 0; b_out_ready = 0;
        fill_random();
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, rd_en, rd_add, rd_bank, busy, unload_done, out_re, out_im, out_index, out_last} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %h required 0",
                {out_valid, rd_en, rd_add, rd_bank, busy, unload_done, out_re, out_im, out_index, out_last}); end
        checks++;
        if ({b_out_valid, b_rd_en, b_rd_add, b_busy, b_unload_done, b_out_index} !== '0)
            begin errors++; $display("FAIL reset_outputs_br: got %h required 0",
                {b_out_valid, b_rd_en, b_rd_add, b_busy, b_unload_done, b_out_index}); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int nb = 0, first_rd = -1, first_valid = -1, last_seen = -1, done_seen = -1;
        int retrig = 0;
        logic [31:0] ew;
        for (int i = 0; i < N; i++) ram0[i] = {16'(i), ~16'(i)};
        res_bank = 0; out_ready = 1;
        fft_done = 1;
        for (int c = 1; c <= 600 && done_seen < 0; c++) begin
            @(negedge clk);
            if (rd_en && first_rd < 0) first_rd = c;
            if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                ew = model_word(1'b0, nb, 1'b0);
                checks++;
                if ({out_re, out_im, out_index, out_last} !== {ew[31:16], ew[15:0], 9'(nb), nb == N-1})
                    begin errors++; $display("FAIL basic_beat: k=%0d got %h/%h/%0d/%b", nb, out_re, out_im, out_index, out_last); end
                if (nb == N-1) last_seen = c;
                nb++;
            end
            if (unload_done) begin
                done_seen = c;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b required 0", busy); end
            end
        end
        checks++;
        if (first_rd != 1) begin errors++; $display("FAIL basic_first_rd: got cycle %0d required 1", first_rd); end
        checks++;
        if (first_valid != 3) begin errors++; $display("FAIL basic_latency: got cycle %0d required 3", first_valid); end
        checks++;
        if (last_seen != N + 2) begin errors++; $display("FAIL basic_throughput: last beat cycle %0d required %0d", last_seen, N + 2); end
        checks++;
        if (done_seen != N + 3) begin errors++; $display("FAIL basic_done: got cycle %0d required %0d", done_seen, N + 3); end
        repeat (20) begin
            @(negedge clk);
            if (busy || unload_done) retrig++;
        end
        checks++;
        if (retrig != 0) begin errors++; $display("FAIL basic_no_retrigger: got %0d busy cycles required 0", retrig); end
        fft_done = 0;
        @(negedge clk);
    endtask

    task automatic test_random_ready();
        int nb = 0, iss0, acc0, outst, max_out = 0;
        bit prev_stall = 0;
        logic [41:0] prev_word;
        logic [31:0] ew;
        fill_random();
        res_bank = 0; out_ready = 0;
        iss0 = issued; acc0 = accepted;
        fft_done = 1;
        for (int c = 0; c < 4000 && nb < N; c++) begin
            @(negedge clk);
            outst = (issued - iss0) - (accepted - acc0);
            if (outst > max_out) max_out = outst;
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_re, out_im, out_index} !== prev_word)
                    begin errors++; $display("FAIL rand_hold: got %h required %h", {out_valid, out_re, out_im, out_index}, prev_word); end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                ew = model_word(1'b0, nb, 1'b0);
                checks++;
                if ({out_re, out_im, out_index, out_last} !== {ew[31:16], ew[15:0], 9'(nb), nb == N-1})
                    begin errors++; $display("FAIL rand_beat: k=%0d got %h/%h/%0d/%b", nb, out_re, out_im, out_index, out_last); end
                nb++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_valid, out_re, out_im, out_index};
        end
        @(negedge clk);
        checks++;
        if (unload_done !== 1'b1) begin errors++; $display("FAIL rand_done: got %b required 1", unload_done); end
        checks++;
        if (nb != N) begin errors++; $display("FAIL rand_count: got %0d beats required %0d", nb, N); end
        checks++;
        if (max_out > 2) begin errors++; $display("FAIL rand_outstanding: got %0d required <=2", max_out); end
        fft_done = 0; out_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int base, nb = 0;
        bit finished = 0;
        logic [31:0] ew;
        fill_random();
        res_bank = 0; out_ready = 0;
        base = add_q.size();
        fft_done = 1;
        repeat (100) @(negedge clk);
        checks++;
        if (add_q.size() - base != 2) begin errors++; $display("FAIL stall_reads: got %0d required 2", add_q.size() - base); end
        out_ready = 1;
        for (int c = 0; c < 700 && !finished; c++) begin
            if (out_valid) begin
                ew = model_word(1'b0, nb, 1'b0);
                checks++;
                if ({out_re, out_im, out_index} !== {ew[31:16], ew[15:0], 9'(nb)})
                    begin errors++; $display("FAIL stall_beat: k=%0d got %h/%h/%0d", nb, out_re, out_im, out_index); end
                nb++;
            end
            @(negedge clk);
            if (unload_done) finished = 1;
        end
        checks++;
        if (add_q.size() < base + 3 || add_q[base + 2] != 2)
            begin errors++; $display("FAIL stall_resume_addr: got %0d required 2", add_q.size() > base + 2 ? add_q[base + 2] : -1); end
        checks++;
        if (nb != N || !finished) begin errors++; $display("FAIL stall_count: got %0d beats done=%b required %0d", nb, finished, N); end
        fft_done = 0; out_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_bitrev();
        int base, nb = 0;
        bit finished = 0;
        logic [31:0] ew;
        fill_random();
        b_res_bank = 1; b_out_ready = 1;
        base = b_add_q.size();
        b_fft_done = 1;
        for (int c = 0; c < 700 && !finished; c++) begin
            @(negedge clk);
            if (b_out_valid) begin
                ew = model_word(1'b1, nb, 1'b1);
                checks++;
                if ({b_out_re, b_out_im, b_out_index, b_rd_bank} !== {ew[31:16], ew[15:0], 9'(nb), 1'b1})
                    begin errors++; $display("FAIL bitrev_beat: k=%0d got %h/%h/%0d bank=%b", nb, b_out_re, b_out_im, b_out_index, b_rd_bank); end
                nb++;
            end
            if (b_unload_done) finished = 1;
        end
        checks++;
        if (b_add_q.size() < base + 4 || b_add_q[base + 1] != 256)
            begin errors++; $display("FAIL bitrev_addr_k1: got %0d required 256", b_add_q.size() > base + 1 ? b_add_q[base + 1] : -1); end
        checks++;
        if (b_add_q.size() < base + 4 || b_add_q[base + 3] != 384)
            begin errors++; $display("FAIL bitrev_addr_k3: got %0d required 384", b_add_q.size() > base + 3 ? b_add_q[base + 3] : -1); end
        checks++;
        if (nb != N || !finished) begin errors++; $display("FAIL bitrev_count: got %0d beats done=%b required %0d", nb, finished, N); end
        b_fft_done = 0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int nb = 0, spurious = 0;
        bit hit = 0, finished = 0;
        logic [31:0] ew;
        fill_random();
        res_bank = 0; out_ready = 1;
        fft_done = 1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (out_valid && out_index == 9'd40) begin
                fft_start = 1;
                hit = 1;
            end
        end
        @(negedge clk);
        checks++;
        if (!hit || out_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL abort_stop: reached=%b out_valid=%b busy=%b required 1/0/0", hit, out_valid, busy); end
        repeat (10) begin
            @(negedge clk);
            if (unload_done || busy || out_valid) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles required 0", spurious); end
        fft_start = 0; fft_done = 0;
        @(negedge clk);
        fft_done = 1;
        for (int c = 0; c < 700 && !finished; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ew = model_word(1'b0, nb, 1'b0);
                checks++;
                if ({out_re, out_im, out_index} !== {ew[31:16], ew[15:0], 9'(nb)})
                    begin errors++; $display("FAIL abort_restart_beat: k=%0d got %h/%h/%0d", nb, out_re, out_im, out_index); end
                nb++;
            end
            if (unload_done) finished = 1;
        end
        checks++;
        if (nb != N || !finished) begin errors++; $display("FAIL abort_restart_count: got %0d beats done=%b required %0d", nb, finished, N); end
        fft_done = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int nb = 0, pulses = 0;
        res_bank = 0; out_ready = 1;
        fft_done = 1;
        repeat (50) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, rd_en, rd_add, rd_bank, busy, unload_done, out_re, out_im, out_index, out_last} !== '0)
            begin errors++; $display("FAIL reset_mid_outputs: got %h required 0",
                {out_valid, rd_en, rd_add, rd_bank, busy, unload_done, out_re, out_im, out_index, out_last}); end
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) nb++;
            if (unload_done) pulses++;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL reset_mid_single_run: got %0d done pulses required 1", pulses); end
        checks++;
        if (nb != N || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_beats: got %0d beats busy=%b required %0d/0", nb, busy, N); end
        fft_done = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_stall();
        test_bitrev();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
